crg_switch_seq: RTL and testbench

// Control-side sequencer for one CRG output channel, running in the ref_clk_i domain.

---
 rtl/crg_switch_seq.sv | 173 +++++++++++++++++
 tb/tb_crg_switch_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crg_switch_seq.sv
// Per-channel CRG sequencer: gate, switch sel, settle, optional reset, ungate; outputs registered.
// Switch latency GATE_CYC+SETTLE_CYC+2 cycles from transfer to done; ready only in IDLE, valid is ignored while busy.
module crg_switch_seq #(
    parameter int M          = 4,
    parameter int GATE_CYC   = 8,
    parameter int SETTLE_CYC = 64,
    parameter int RST_CYC    = 16,
    localparam int SW        = (M > 1) ? $clog2(M) : 1
) (
    input  logic          ref_clk_i,
    input  logic          glob_arst_ni,
    input  logic          user_en_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [SW-1:0] req_sel_i,
    input  logic          req_rst_i,
    output logic [SW-1:0] sel_o,
    output logic          en_o,
    output logic          arst_req_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int MAXC = (GATE_CYC > SETTLE_CYC)
                        ? ((GATE_CYC > RST_CYC) ? GATE_CYC : RST_CYC)
                        : ((SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC);
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] GATE_LD   = CW'(GATE_CYC);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] RST_LD    = CW'(RST_CYC);
    localparam logic [CW-1:0] INIT_LD   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [SW:0]   M_LIM     = (SW + 1)'(M);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_GATE, S_SWITCH, S_RESET, S_UNGATE
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [SW-1:0] r_sel, w_sel;
    logic [SW-1:0] r_hold_sel, w_hold_sel;
    logic          r_hold_rst, w_hold_rst;
    logic          r_gate, w_gate;
    logic          r_arst, w_arst;
    logic          r_done, w_done;
    logic          r_err, w_err;
    logic          w_last;
    logic          w_sel_bad;

    assign w_last    = (r_cnt == ONE);
    assign w_sel_bad = ({1'b0, req_sel_i} >= M_LIM);

    always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
        if (!glob_arst_ni) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_hold_sel <= '0;
            r_hold_rst <= 1'b0;
            r_gate     <= 1'b1;
            r_arst     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sel      <= w_sel;
            r_hold_sel <= w_hold_sel;
            r_hold_rst <= w_hold_rst;
            r_gate     <= w_gate;
            r_arst     <= w_arst;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sel      = r_sel;
        w_hold_sel = r_hold_sel;
        w_hold_rst = r_hold_rst;
        w_gate     = r_gate;
        w_arst     = r_arst;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_INIT: begin
                // cnt comes out of reset at 0, so the first INIT cycle loads the remaining count
                if (w_last || (r_cnt == '0 && RST_CYC == 1)) begin
                    w_state = S_IDLE;
                    w_arst  = 1'b0;
                    w_gate  = 1'b0;
                    w_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_cnt = INIT_LD;
                end else begin
                    w_cnt = r_cnt - ONE;
                end
            end
            S_IDLE: begin
                if (req_valid_i) begin
                    w_hold_sel = req_sel_i;
                    w_hold_rst = req_rst_i;
                    if (w_sel_bad) begin
                        w_err = 1'b1;
                    end else if (req_sel_i == r_sel && !req_rst_i) begin
                        w_done = 1'b1;
                    end else if (req_sel_i == r_sel) begin
                        w_state = S_RESET;
                        w_cnt   = RST_LD;
                        w_arst  = 1'b1;
                    end else begin
                        w_state = S_GATE;
                        w_cnt   = GATE_LD;
                        w_gate  = 1'b1;
                    end
                end
            end
            S_GATE: begin
                if (w_last) begin
                    w_state = S_SWITCH;
                    w_cnt   = SETTLE_LD;
                    w_sel   = r_hold_sel;
                end else begin
                    w_cnt = r_cnt - ONE;
                end
            end
            S_SWITCH: begin
                if (w_last) begin
                    if (r_hold_rst) begin
                        w_state = S_RESET;
                        w_cnt   = RST_LD;
                        w_arst  = 1'b1;
                    end else begin
                        w_state = S_UNGATE;
                    end
                end else begin
                    w_cnt = r_cnt - ONE;
                end
            end
            S_RESET: begin
                if (w_last) begin
                    w_state = S_UNGATE;
                    w_arst  = 1'b0;
                end else begin
                    w_cnt = r_cnt - ONE;
                end
            end
            S_UNGATE: begin
                w_state = S_IDLE;
                w_gate  = 1'b0;
                w_arst  = 1'b0;
                w_done  = 1'b1;
            end
            default: begin
                w_state = S_INIT;
            end
        endcase
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign sel_o       = r_sel;
    assign en_o        = user_en_i & ~r_gate;
    assign arst_req_o  = r_arst;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_crg_switch_seq.sv
// Bench for crg_switch_seq: directed requests, done/err pulses checked against a timed scoreboard.
module tb_crg_switch_seq;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       user_en = 1'b1;

    logic       a_vld = 1'b0;
    logic [1:0] a_sel = '0;
    logic       a_rst = 1'b0;
    logic       a_rdy, a_en, a_arst, a_busy, a_done, a_err;
    logic [1:0] a_sel_o;

    logic       b_vld = 1'b0;
    logic [1:0] b_sel = '0;
    logic       b_rst = 1'b0;
    logic       b_rdy, b_en, b_arst, b_busy, b_done, b_err;
    logic [1:0] b_sel_o;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit is_err;
        int at;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crg_switch_seq u_a (
        .ref_clk_i(clk), .glob_arst_ni(arst_n), .user_en_i(user_en),
        .req_valid_i(a_vld), .req_ready_o(a_rdy), .req_sel_i(a_sel), .req_rst_i(a_rst),
        .sel_o(a_sel_o), .en_o(a_en), .arst_req_o(a_arst), .busy_o(a_busy),
        .done_o(a_done), .err_o(a_err)
    );

    crg_switch_seq #(.M(3)) u_b (
        .ref_clk_i(clk), .glob_arst_ni(arst_n), .user_en_i(user_en),
        .req_valid_i(b_vld), .req_ready_o(b_rdy), .req_sel_i(b_sel), .req_rst_i(b_rst),
        .sel_o(b_sel_o), .en_o(b_en), .arst_req_o(b_arst), .busy_o(b_busy),
        .done_o(b_done), .err_o(b_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // lat = cycles from the transfer cycle to the done/err pulse; lat <= 0 pushes nothing
    task automatic send(input bit to_b, input int sel, input bit rst, input int lat, input bit is_err);
        int  n;
        bit  rdy;
        exp_t e;
        n = 0;
        @(negedge clk);
        if (to_b) begin
            b_vld = 1'b1; b_sel = sel[1:0]; b_rst = rst;
        end else begin
            a_vld = 1'b1; a_sel = sel[1:0]; a_rst = rst;
        end
        rdy = to_b ? b_rdy : a_rdy;
        while (!rdy && n < 300) begin
            @(negedge clk);
            n++;
            rdy = to_b ? b_rdy : a_rdy;
        end
        chk("handshake_ready", int'(rdy), 1);
        if (rdy && lat > 0) begin
            e.is_err = is_err;
            e.at     = cyc + lat;
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        @(negedge clk);
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (!a_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_reached", int'(a_rdy), 1);
    endtask

    task automatic count_arst_a(output int n, output bit en_seen);
        n = 0;
        en_seen = 1'b0;
        while (a_arst && n < 100) begin
            en_seen = en_seen | a_en;
            n++;
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (arst_n && (a_done || a_err)) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_pulse", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_pulse_kind_err", int'(a_err), int'(e.is_err));
                chk("a_pulse_cycle", cyc, e.at);
            end
        end
        if (arst_n && (b_done || b_err)) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_pulse", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_pulse_kind_err", int'(b_err), int'(e.is_err));
                chk("b_pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bit en_seen;

        // reset state
        @(negedge clk);
        chk("rst_sel", int'(a_sel_o), 0);
        chk("rst_en", int'(a_en), 0);
        chk("rst_arst", int'(a_arst), 1);
        chk("rst_ready", int'(a_rdy), 0);
        chk("rst_busy", int'(a_busy), 1);
        chk("rst_done_err", int'({a_done, a_err}), 0);

        // INIT sequence after release
        @(negedge clk);
        arst_n = 1'b1;
        count_arst_a(n, en_seen);
        chk("init_arst_len", n, 16);
        chk("init_en_low", int'(en_seen), 0);
        chk("init_ready", int'(a_rdy), 1);
        chk("init_busy", int'(a_busy), 0);
        chk("init_sel", int'(a_sel_o), 0);
        chk("init_en_follows_user", int'(a_en), 1);
        user_en = 1'b0;
        #1;
        chk("user_en_off", int'(a_en), 0);
        user_en = 1'b1;
        #1;
        chk("user_en_on", int'(a_en), 1);

        // switch 0 -> 2 without reset
        send(1'b0, 2, 1'b0, 74, 1'b0);
        n = 0;
        while (!a_en && a_sel_o == 2'd0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("sw2_gate_len", n, 8);
        chk("sw2_sel_new", int'(a_sel_o), 2);
        chk("sw2_en_still_low", int'(a_en), 0);
        wait_idle_a();
        chk("sw2_en_restored", int'(a_en), 1);

        // switch 2 -> 3 with reset
        send(1'b0, 3, 1'b1, 90, 1'b0);
        n = 0;
        while (!a_arst && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("sw3_arst_start", n, 72);
        count_arst_a(n, en_seen);
        chk("sw3_arst_len", n, 16);
        chk("sw3_en_low_in_rst", int'(en_seen), 0);
        chk("sw3_sel", int'(a_sel_o), 3);
        wait_idle_a();

        // same source: plain done, then reset-only
        send(1'b0, 3, 1'b0, 1, 1'b0);
        chk("same_no_gate_en", int'(a_en), 1);
        chk("same_not_busy", int'(a_busy), 0);
        send(1'b0, 3, 1'b1, 18, 1'b0);
        count_arst_a(n, en_seen);
        chk("rstonly_arst_len", n, 16);
        chk("rstonly_en_kept", int'(en_seen), 1);
        chk("rstonly_sel", int'(a_sel_o), 3);
        wait_idle_a();

        // out-of-range source on the M=3 instance, then a same-source request
        send(1'b1, 3, 1'b0, 1, 1'b1);
        chk("err_sel_unchanged", int'(b_sel_o), 0);
        chk("err_en_unchanged", int'(b_en), 1);
        chk("err_not_busy", int'(b_busy), 0);
        send(1'b1, 0, 1'b0, 1, 1'b0);

        // second request held valid while the first is in flight
        send(1'b0, 0, 1'b0, 74, 1'b0);
        send(1'b0, 1, 1'b0, 74, 1'b0);
        wait_idle_a();
        chk("held_req_sel", int'(a_sel_o), 1);

        // reset in the middle of SETTLE
        send(1'b0, 2, 1'b0, 0, 1'b0);
        repeat (30) @(negedge clk);
        chk("mid_in_switch_sel", int'(a_sel_o), 2);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_sel", int'(a_sel_o), 0);
        chk("mid_rst_en", int'(a_en), 0);
        chk("mid_rst_arst", int'(a_arst), 1);
        chk("mid_rst_ready", int'(a_rdy), 0);
        chk("mid_rst_busy", int'(a_busy), 1);
        @(negedge clk);
        arst_n = 1'b1;
        count_arst_a(n, en_seen);
        chk("reinit_arst_len", n, 16);
        chk("reinit_ready", int'(a_rdy), 1);
        chk("reinit_sel", int'(a_sel_o), 0);

        repeat (5) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
